hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory
// wait-state freezes, with a memory-wait timeout and saturating performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1_addr,
    input  logic [4:0]       if_id_rs2_addr,
    input  logic             if_id_uses_rs1,
    input  logic             if_id_uses_rs2,
    input  logic [4:0]       id_ex_rd_addr,
    input  logic             id_ex_memread,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_flush,
    output logic             ex_mem_write_en,
    output logic             mem_wb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic mem_freeze_c;
    logic load_use_c;

    // Hazard detection
    always_comb begin
        mem_freeze_c = 1'b0;
        case (state_q)
            ST_IDLE: mem_freeze_c = dmem_req && !dmem_ready;
            ST_WAIT: mem_freeze_c = !dmem_ready;
            default: mem_freeze_c = 1'b0;
        endcase

        load_use_c = id_ex_memread && (id_ex_rd_addr != 5'd0) &&
                     ((if_id_uses_rs1 && (id_ex_rd_addr == if_id_rs1_addr)) ||
                      (if_id_uses_rs2 && (id_ex_rd_addr == if_id_rs2_addr)));
    end

    // Mealy pipeline controls, priority freeze > branch > load-use
    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_bubble   = 1'b0;

        if (rst) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_freeze_c) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use_c) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end
    end

    // Memory-wait FSM and saturating counters
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (dmem_req && !dmem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_LAST) begin
                    state_d    = ST_ERR;
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase

        stall_d = stall_q;
        if (!pc_write_en && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        flush_d = flush_q;
        if (if_id_flush && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_cycles    = stall_q;
    assign flush_events    = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed and randomized checks of hazard_stall_ctrl against a behavioural model
// that tracks frozen-cycle runs and saturating event counts.
module tb_hazard_stall_ctrl;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int          CNT_MAX     = 15;

    logic             clk;
    logic             rst;
    logic [4:0]       if_id_rs1_addr;
    logic [4:0]       if_id_rs2_addr;
    logic             if_id_uses_rs1;
    logic             if_id_uses_rs2;
    logic [4:0]       id_ex_rd_addr;
    logic             id_ex_memread;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_write_en;
    logic             id_ex_flush;
    logic             ex_mem_write_en;
    logic             mem_wb_bubble;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    hazard_stall_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_rs1_addr (if_id_rs1_addr),
        .if_id_rs2_addr (if_id_rs2_addr),
        .if_id_uses_rs1 (if_id_uses_rs1),
        .if_id_uses_rs2 (if_id_uses_rs2),
        .id_ex_rd_addr  (id_ex_rd_addr),
        .id_ex_memread  (id_ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .if_id_flush    (if_id_flush),
        .id_ex_write_en (id_ex_write_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_write_en(ex_mem_write_en),
        .mem_wb_bubble  (mem_wb_bubble),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: length of the current run of frozen cycles, sticky error, event counts
    int m_run   = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        if_id_rs1_addr  = 5'd0;
        if_id_rs2_addr  = 5'd0;
        if_id_uses_rs1  = 1'b0;
        if_id_uses_rs2  = 1'b0;
        id_ex_rd_addr   = 5'd0;
        id_ex_memread   = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        id_ex_memread  = 1'b1;
        id_ex_rd_addr  = r;
        if_id_rs1_addr = r;
        if_id_uses_rs1 = 1'b1;
    endtask

    // Check one cycle (inputs already driven after a falling edge), then advance the model
    task automatic cycle();
        logic       freeze;
        logic       lu;
        logic [6:0] exp;
        logic [6:0] got;
        #2;
        freeze = 1'b0;
        lu     = id_ex_memread && (id_ex_rd_addr != 5'd0) &&
                 ((if_id_uses_rs1 && id_ex_rd_addr == if_id_rs1_addr) ||
                  (if_id_uses_rs2 && id_ex_rd_addr == if_id_rs2_addr));
        if (rst) begin
            exp = 7'b1111111;
        end else begin
            if (!m_err) freeze = (m_run > 0) ? !dmem_ready : (dmem_req && !dmem_ready);
            if (freeze)               exp = 7'b0000001;
            else if (ex_branch_taken) exp = 7'b1111110;
            else if (lu)              exp = 7'b0001110;
            else                      exp = 7'b1101010;
        end
        got = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
               id_ex_flush, ex_mem_write_en, mem_wb_bubble};
        check("ctrl", 32'(got), 32'(exp));
        check("timeout_err", 32'(mem_timeout_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("flush_events", 32'(flush_events), 32'(m_flush));
        @(posedge clk);
        if (rst) begin
            m_run   = 0;
            m_err   = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!exp[6] && m_stall < CNT_MAX) m_stall++;
            if (exp[4] && m_flush < CNT_MAX) m_flush++;
            if (freeze) begin
                m_run++;
                if (m_run == MEM_TIMEOUT) begin
                    m_err = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int s0;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Single load-use bubble
        set_load_use(5'd5);
        cycle();
        clear_inputs();
        cycle();
        check("lu_single_stall", 32'(stall_cycles), 32'd1);

        // No stall: rd=0 load, and rs2 match without uses_rs2
        set_load_use(5'd0);
        cycle();
        clear_inputs();
        id_ex_memread  = 1'b1;
        id_ex_rd_addr  = 5'd7;
        if_id_rs2_addr = 5'd7;
        cycle();
        clear_inputs();

        // Taken branch wins over load-use
        set_load_use(5'd9);
        ex_branch_taken = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        check("branch_flush_cnt", 32'(flush_events), 32'd1);
        check("branch_no_stall", 32'(stall_cycles), 32'd1);

        // Three wait states then ready
        s0 = int'(stall_cycles);
        dmem_req = 1'b1;
        repeat (3) cycle();
        dmem_ready = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        check("wait3_stall", 32'(stall_cycles), 32'(s0 + 3));

        // Timeout, then error holds while dmem toggles, cleared by reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        dmem_req = 1'b1;
        repeat (MEM_TIMEOUT) cycle();
        check("timeout_set", 32'(mem_timeout_err), 32'd1);
        check("timeout_stall_sat", 32'(stall_cycles), 32'(CNT_MAX));
        for (int i = 0; i < 8; i++) begin
            dmem_req   = 1'(i);
            dmem_ready = 1'(i >> 1);
            cycle();
        end
        check("err_sticky", 32'(mem_timeout_err), 32'd1);
        clear_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("err_cleared", 32'(mem_timeout_err), 32'd0);

        // Counter saturation from repeated load-use stalls
        repeat (20) begin
            set_load_use(5'd3);
            cycle();
            clear_inputs();
            cycle();
        end
        check("stall_saturate", 32'(stall_cycles), 32'(CNT_MAX));

        // Reset in the middle of a wait
        dmem_req = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        dmem_req = 1'b0;
        cycle();
        check("rst_wait_no_freeze", 32'(pc_write_en), 32'd1);
        check("rst_wait_stall_clr", 32'(stall_cycles), 32'd0);

        // Randomized traffic with occasional resets and long wait runs
        for (int n = 0; n < 3000; n++) begin
            if_id_rs1_addr  = 5'($urandom_range(0, 3));
            if_id_rs2_addr  = 5'($urandom_range(0, 3));
            if_id_uses_rs1  = 1'($urandom_range(0, 1));
            if_id_uses_rs2  = 1'($urandom_range(0, 1));
            id_ex_rd_addr   = 5'($urandom_range(0, 3));
            id_ex_memread   = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req        = ($urandom_range(0, 2) == 0);
            dmem_ready      = ((n / 100) % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) != 0);
            rst             = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 1'b0;
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
